bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single slave-side bus between the four bus masters m0–m3. It produces the active-low grant lines that select which master's address, strobe, R/W and write data drive the shared bus through the master multiplexer. Ownership is registered and parked on the last owner. A hold limit stops one master from starving the others.

---
 rtl/bus_arbiter.sv | 113 +++++++++++
 tb/tb_bus_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter for the shared slave-side bus used by masters m0..m3.
// Ownership is registered and parks on the last owner when nobody asks for
// the bus. A contested owner is preempted after HOLD_MAX contested cycles
// (HOLD_MAX = 0 disables preemption).
//
// state | meaning
// ------+-------------------------------------------------------------
// owner | index of the master currently driving the shared bus
//
// Ports:
//   clk                  system clock, rising edge
//   reset_               synchronous active-low reset
//   m0_req_ .. m3_req_   bus requests, active-low
//   m0_grnt_ .. m3_grnt_ bus grants, active-low, registered, exactly one low
//   owner                registered index of the current owner
//   contend              owner requesting while another master also requests
module bus_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       contend
);

    localparam int HOLD_LAST_I = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_I[CNT_W-1:0];

    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       grnt_q, grnt_d;

    logic [3:0] req;
    logic [3:0] others;
    logic [1:0] cand1, cand2, cand3;
    logic       scan_found;
    logic [1:0] scan_idx;
    logic       do_release;
    logic       do_preempt;

    assign req    = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign others = req & ~(4'b0001 << owner_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            owner_q    <= 2'd0;
            hold_cnt_q <= '0;
            grnt_q     <= 4'b1110;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            grnt_q     <= grnt_d;
        end
    end

    // Next-state: round-robin scan starting just after the current owner.
    always_comb begin
        cand1      = owner_q + 2'd1;
        cand2      = owner_q + 2'd2;
        cand3      = owner_q + 2'd3;
        scan_found = 1'b1;
        scan_idx   = owner_q;
        if (req[cand1]) begin
            scan_idx = cand1;
        end else if (req[cand2]) begin
            scan_idx = cand2;
        end else if (req[cand3]) begin
            scan_idx = cand3;
        end else begin
            scan_found = 1'b0;
        end

        contend    = req[owner_q] && (others != 4'b0000);
        do_release = !req[owner_q] && scan_found;
        do_preempt = (HOLD_MAX != 0) && contend && (hold_cnt_q == HOLD_LAST);

        owner_d = owner_q;
        if (do_release || do_preempt) begin
            owner_d = scan_idx;
        end

        // Saturate rather than wrap so a disabled limit never aliases.
        hold_cnt_d = hold_cnt_q;
        if (do_release || do_preempt || !contend) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end

        grnt_d = ~(4'b0001 << owner_d);
    end

    // Outputs straight from flops so grants are glitch-free.
    always_comb begin
        owner    = owner_q;
        m0_grnt_ = grnt_q[0];
        m1_grnt_ = grnt_q[1];
        m2_grnt_ = grnt_q[2];
        m3_grnt_ = grnt_q[3];
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Two instances share the request inputs:
// dut4 with HOLD_MAX=4 and dut0 with preemption disabled.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset_;
    logic m0_req_, m1_req_, m2_req_, m3_req_;

    logic       g4_0, g4_1, g4_2, g4_3, c4;
    logic [1:0] o4;
    logic       g0_0, g0_1, g0_2, g0_3, c0;
    logic [1:0] o0;
    logic [3:0] g4, g0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign g4 = {g4_3, g4_2, g4_1, g4_0};
    assign g0 = {g0_3, g0_2, g0_1, g0_0};

    bus_arbiter #(.HOLD_MAX(4), .CNT_W(5)) dut4 (
        .clk(clk), .reset_(reset_),
        .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
        .m0_grnt_(g4_0), .m1_grnt_(g4_1), .m2_grnt_(g4_2), .m3_grnt_(g4_3),
        .owner(o4), .contend(c4)
    );

    bus_arbiter #(.HOLD_MAX(0), .CNT_W(5)) dut0 (
        .clk(clk), .reset_(reset_),
        .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
        .m0_grnt_(g0_0), .m1_grnt_(g0_1), .m2_grnt_(g0_2), .m3_grnt_(g0_3),
        .owner(o0), .contend(c0)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // r is active-high, bit n = master n requesting.
    task automatic set_req(input logic [3:0] r);
        {m3_req_, m2_req_, m1_req_, m0_req_} = ~r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int bad;

    initial begin
        reset_ = 1'b0;
        set_req(4'b1111);
        tick();
        tick();
        reset_ = 1'b1;
        chk("rst_owner", o4, 0);
        chk("rst_grnt", g4, 4'b1110);
        chk("rst_grnt_d0", g0, 4'b1110);
        chk("rst_cnt", dut4.hold_cnt_q, 0);

        set_req(4'b0100);
        tick();
        chk("rst_then_m2_owner", o4, 2);
        chk("rst_then_m2_grnt", g4, 4'b1011);

        // Single request from idle owner 0.
        reset_ = 1'b0;
        set_req(4'b0000);
        tick();
        reset_ = 1'b1;
        chk("idle_owner", o4, 0);
        chk("idle_contend", c4, 0);
        set_req(4'b1000);
        tick();
        chk("single_owner", o4, 3);
        chk("single_grnt", g4, 4'b0111);
        set_req(4'b0000);
        tick();
        tick();
        chk("park_owner", o4, 3);
        chk("park_grnt", g4, 4'b0111);

        // Round robin from owner 1.
        set_req(4'b0010);
        tick();
        chk("rr_setup_owner", o4, 1);
        set_req(4'b1101);
        tick();
        chk("rr_m2_grant", g4, 4'b1011);
        tick();
        chk("rr_m2_hold1", o4, 2);
        tick();
        chk("rr_m2_hold2", o4, 2);
        chk("rr_m2_cnt", dut4.hold_cnt_q, 2);
        set_req(4'b1001);
        tick();
        chk("rr_m3_grant", g4, 4'b0111);
        tick();
        chk("rr_m3_hold1", o4, 3);
        tick();
        chk("rr_m3_hold2", o4, 3);
        set_req(4'b0001);
        tick();
        chk("rr_m0_grant", g4, 4'b1110);
        tick();
        chk("rr_m0_hold1", o4, 0);
        tick();
        chk("rr_m0_hold2", o4, 0);
        set_req(4'b0000);
        tick();
        chk("rr_m0_park", o4, 0);

        // Preemption with HOLD_MAX=4.
        set_req(4'b0010);
        tick();
        chk("pre_m1_owner", o4, 1);
        tick();
        chk("pre_m1_nocontend", c4, 0);
        set_req(4'b0110);
        #1;
        chk("pre_contend", c4, 1);
        tick();
        chk("pre_k0_owner", o4, 1);
        tick();
        chk("pre_k1_owner", o4, 1);
        tick();
        chk("pre_k2_owner", o4, 1);
        chk("pre_k2_cnt", dut4.hold_cnt_q, 3);
        tick();
        chk("pre_k3_grnt", g4, 4'b1011);
        chk("pre_k3_owner", o4, 2);
        chk("pre_k3_cnt", dut4.hold_cnt_q, 0);
        chk("nopre_k3_owner", o0, 1);

        // Preemption disabled: m1 keeps the bus under contention.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o0 != 2'd1 || g0 != 4'b1101) bad++;
        end
        chk("nopre_100_cycles", bad, 0);
        set_req(4'b0100);
        tick();
        chk("nopre_release_owner", o0, 2);
        chk("nopre_release_grnt", g0, 4'b1011);

        // Mid-transfer reset from owner 3 with everyone requesting.
        set_req(4'b1000);
        tick();
        chk("mid_setup_owner", o4, 3);
        set_req(4'b1111);
        tick();
        tick();
        chk("mid_cnt_before", dut4.hold_cnt_q, 2);
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        chk("mid_rst_owner", o4, 0);
        chk("mid_rst_grnt", g4, 4'b1110);
        chk("mid_rst_cnt", dut4.hold_cnt_q, 0);
        tick();
        chk("mid_after_owner", o4, 0);
        chk("mid_after_cnt", dut4.hold_cnt_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
